// File: rtl/cini_pkg.sv
// Shared definitions for the CINI masked/triplicated output blocks.
//   cini_state_e : health FSM states (OK, DEGRADED, ALARM)
//   REPLICAS     : replication factor of the triplicated gadgets
//   rep_lsb()    : LSB of replica r inside a packed REPLICAS*w vector
package cini_pkg;
    localparam int REPLICAS = 3;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_ALARM    = 2'd2
    } cini_state_e;

    function automatic int rep_lsb(input int r, input int w);
        return r * w;
    endfunction
endpackage

// File: rtl/cini_maj3_vote.sv
// Combinational 3-way bitwise majority vote with a replica mismatch flag.
//   a, b, c  : replica values
//   maj      : bitwise majority of a, b, c
//   mismatch : 1 when any replica differs from the others
module cini_maj3_vote #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] maj,
    output logic             mismatch
);
    assign maj      = (a & b) | (b & c) | (a & c);
    // a==b and b==c implies all three equal, so two compares suffice.
    assign mismatch = (a != b) | (b != c);
endmodule

// File: rtl/cini_unmask_decoder.sv
// Output-side decoder for CINI 2-share, 3-way replicated masked values.
// Shares are registered (S1) before being recombined (S2), so no
// combinational path ever mixes share 0 with share 1. The unmasked replicas
// are majority-voted into the output register, replica disagreement is
// flagged, counted (saturating) and escalated through a sticky alarm FSM.
//
// Ports:
//   clk, reset                     : clock, async active-low reset
//   port_c_0, port_c_1             : shares, replica r at [r*WIDTH +: WIDTH]
//   port_in_valid / port_in_ready  : input handshake
//   port_out_valid / port_out_ready: output handshake
//   port_out_data, port_out_fault  : voted data and mismatch flag
//   port_fault_cnt, port_alarm     : fault counter and sticky alarm
//   port_clear                     : sync clear of counter and FSM
//
// Optional build macro CINI_DEC_ZEROIZE_EN: when defined, port_out_data reads
// 0 while the alarm is raised.
module cini_unmask_decoder
    import cini_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int FAULT_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REPLICAS*WIDTH-1:0] port_c_0,
    input  logic [REPLICAS*WIDTH-1:0] port_c_1,
    input  logic                      port_in_valid,
    output logic                      port_in_ready,
    output logic                      port_out_valid,
    input  logic                      port_out_ready,
    output logic [WIDTH-1:0]          port_out_data,
    output logic                      port_out_fault,
    output logic [CNT_W-1:0]          port_fault_cnt,
    output logic                      port_alarm,
    input  logic                      port_clear
);
    logic                      s1_vld, s2_vld, out_vld;
    logic [REPLICAS*WIDTH-1:0] s1_c0, s1_c1, s2_u, u_nxt;
    logic [WIDTH-1:0]          out_data, vote;
    logic                      out_fault, mism;
    logic                      out_take, s2_take, s1_take;

    // Each stage may load when empty or when its contents move on this cycle.
    assign out_take      = !out_vld | port_out_ready;
    assign s2_take       = !s2_vld | out_take;
    assign s1_take       = !s1_vld | s2_take;
    assign port_in_ready = s1_take;

    genvar r;
    generate
        for (r = 0; r < REPLICAS; r++) begin : g_unmask
            assign u_nxt[rep_lsb(r, WIDTH) +: WIDTH] =
                s1_c0[rep_lsb(r, WIDTH) +: WIDTH] ^ s1_c1[rep_lsb(r, WIDTH) +: WIDTH];
        end
    endgenerate

    cini_maj3_vote #(.WIDTH(WIDTH)) u_vote (
        .a        (s2_u[rep_lsb(0, WIDTH) +: WIDTH]),
        .b        (s2_u[rep_lsb(1, WIDTH) +: WIDTH]),
        .c        (s2_u[rep_lsb(2, WIDTH) +: WIDTH]),
        .maj      (vote),
        .mismatch (mism)
    );

    // Data registers only load on a valid beat so bubbles never overwrite data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld    <= 1'b0;
            s1_c0     <= '0;
            s1_c1     <= '0;
            s2_vld    <= 1'b0;
            s2_u      <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_fault <= 1'b0;
        end else begin
            if (s1_take) begin
                s1_vld <= port_in_valid;
                if (port_in_valid) begin
                    s1_c0 <= port_c_0;
                    s1_c1 <= port_c_1;
                end
            end
            if (s2_take) begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_u <= u_nxt;
            end
            if (out_take) begin
                out_vld <= s2_vld;
                if (s2_vld) begin
                    out_data  <= vote;
                    out_fault <= mism;
                end
            end
        end
    end

    // Fault accounting on the output transfer.
    cini_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
    logic             fault_xfer;

    assign fault_xfer = out_vld & port_out_ready & out_fault;
    assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        if (port_clear) begin
            cnt_nxt   = '0;
            state_nxt = ST_OK;
        end else if (fault_xfer) begin
            cnt_nxt = cnt_inc;
            case (state)
                ST_OK:       state_nxt = (int'(cnt_inc) >= FAULT_LIMIT) ? ST_ALARM : ST_DEGRADED;
                ST_DEGRADED: state_nxt = (int'(cnt_inc) >= FAULT_LIMIT) ? ST_ALARM : ST_DEGRADED;
                ST_ALARM:    state_nxt = ST_ALARM;
                default:     state_nxt = ST_ALARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_OK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign port_out_valid = out_vld;
    assign port_out_fault = out_fault;
    assign port_fault_cnt = cnt;
    assign port_alarm     = (state == ST_ALARM);

`ifdef CINI_DEC_ZEROIZE_EN
    assign port_out_data = port_alarm ? '0 : out_data;
`else
    assign port_out_data = out_data;
`endif
endmodule

// File: doc/cini_unmask_decoder.md
Name: cini_unmask_decoder

Overview:
- Output-side consumer for the CINI3-style masked, triplicated gadgets.
- Accepts a 2-share, 3-way replicated masked value and registers both shares before recombining them, so no combinational logic ever mixes shares.
- Unmasks each replica, majority-votes the result and flags replica disagreement as a fault.
- Keeps a saturating fault counter and a sticky alarm FSM; delivers plain data over a valid/ready handshake.

Parameters:
- WIDTH, 1, logical data bits per replica.
- FAULT_LIMIT, 4, number of faulty beats that escalates the FSM to ALARM (range 1..255).
- CNT_W, 8, fault counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- port_c_0  input  3*WIDTH  share 0; replica r occupies bits [r*WIDTH +: WIDTH].
- port_c_1  input  3*WIDTH  share 1, same layout.
- port_in_valid  input  1  input beat valid.
- port_in_ready  output  1  decoder can accept a beat.
- port_out_valid  output  1  decoded beat valid.
- port_out_ready  input  1  downstream accepts the beat.
- port_out_data  output  WIDTH  majority-voted plain value.
- port_out_fault  output  1  beat had replica disagreement; qualified by port_out_valid.
- port_fault_cnt  output  CNT_W  saturating count of faulty beats.
- port_alarm  output  1  sticky alarm.
- port_clear  input  1  synchronous clear of the counter and alarm.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all pipeline registers and valid flags to 0;
  - port_out_data, port_out_fault and port_fault_cnt to 0;
  - the FSM to OK, so port_alarm=0.
- Pipeline:
  - S1 registers port_c_0 and port_c_1 unchanged.
  - S2 registers each replica r as u_r = c0_r ^ c1_r.
  - The output register holds maj(u0,u1,u2) bitwise and fault = (u0!=u1)|(u1!=u2).
- Latency: 3 cycles from an accepted input to port_out_valid with no backpressure; throughput is 1 beat per cycle.
- Handshake:
  - Input is accepted on port_in_valid & port_in_ready.
  - A stage advances when its successor is empty or is being drained in the same cycle.
  - port_in_ready = !S1.valid | S1 advancing.
  - The output holds data and fault stable while port_out_valid & !port_out_ready.
- Bubbles never corrupt data. Unaccepted beats are not counted.
- Fault accounting:
  - Happens on the output transfer (port_out_valid & port_out_ready & port_out_fault).
  - The counter increments and saturates at 2^CNT_W-1.
- FSM states:
  - OK -> DEGRADED on the first faulty transfer.
  - DEGRADED -> ALARM when the counter reaches FAULT_LIMIT after the increment. With FAULT_LIMIT=1, OK goes directly to ALARM.
  - ALARM is sticky; port_alarm=1 only in ALARM.
- port_clear:
  - Resets the counter to 0 and the FSM to OK next cycle; pipeline data is unaffected.
  - If a faulty transfer coincides with clear, clear wins: counter=0, state OK.
- Mid-operation reset: in-flight beats are discarded and no output beat appears afterwards until new input.

Optional Feature:
- Macro: CINI_DEC_ZEROIZE_EN.
- Defined: while port_alarm=1, port_out_data is forced to 0. Handshake and fault flag are unchanged, and the counter still counts.
- Undefined: data always passes through regardless of alarm.

Decomposition:
- Shared package cini_pkg holds:
  - the FSM state enum (OK, DEGRADED, ALARM);
  - the constant REPLICAS=3 and the replica slice helper.
- One natural sub-module, cini_maj3_vote: combinational 3-way bitwise majority plus mismatch flag, reused by other CINI blocks.

Test Plan:
1. Reset, then WIDTH=1, c0=3'b101, c1=3'b010, valid held, out_ready=1 -> out_valid at cycle 3, data=1, fault=0, cnt=0.
2. Single-replica flip: c0=3'b100, c1=3'b000 -> data=0, fault=1, cnt=1, FSM DEGRADED, alarm=0.
3. Four faulty beats back-to-back (FAULT_LIMIT=4) -> alarm rises the cycle after the 4th transfer and stays 1 through subsequent clean beats; port_clear -> cnt=0, alarm=0.
4. Backpressure: stream values 1,0,1 with out_ready=0 for 5 cycles -> in_ready drops after the pipeline fills, out_data holds 1 stable, and releasing ready delivers 1,0,1 in order with no loss or duplication.
5. Reset asserted mid-stream with 2 beats in flight -> out_valid=0 immediately, no stale beat after release.
6. CINI_DEC_ZEROIZE_EN defined, alarm set, clean beat of value 1 -> out_data=0, fault=0, out_valid=1.
